// File: rtl/img_proc_pkg.sv
// Shared definitions for the img_proc pixel-stream stages: pixel constants,
// the common stage state encoding and a counter-width helper.
package img_proc_pkg;

   localparam int unsigned PIX_W = 8;

   // Binary pixel levels produced by thresholding stages
   localparam logic [PIX_W-1:0] PIX_FG = 8'hFF;
   localparam logic [PIX_W-1:0] PIX_BG = 8'h00;

   // Frame-level state shared by stream stages
   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StFlush,
      StDone
   } img_state_e;

   // Counter width for a range of n values, never narrower than one bit
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position counter. Advances one pixel per advance_i pulse,
// wraps x at the end of a line and y at the end of a frame; clear_i has
// priority and returns the position to the origin.
module raster_counter
   import img_proc_pkg::*;
#(
   parameter int unsigned WIDTH  = 640,
   parameter int unsigned HEIGHT = 480,
   localparam int unsigned XW    = cnt_w(WIDTH),
   localparam int unsigned YW    = cnt_w(HEIGHT)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          advance_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o
);

   localparam logic [XW-1:0] XMax = XW'(WIDTH - 1);
   localparam logic [YW-1:0] YMax = YW'(HEIGHT - 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   // Next position: clear wins, otherwise step with line/frame wrap
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear_i) begin
         x_d = '0;
         y_d = '0;
      end else if (advance_i) begin
         if (x_q == XMax) begin
            x_d = '0;
            y_d = (y_q == YMax) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   // Position registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o = x_q;
   assign y_o = y_q;

endmodule

// File: rtl/binarize_stream.sv
// Thresholds a raster-order grayscale stream into binary pixels for the
// morphological filters, then emits padding so their line window flushes.
// Optional macro BINARIZE_STATS_EN adds the per-frame fg_count output.
module binarize_stream
   import img_proc_pkg::*;
#(
   parameter int unsigned       IMG_WIDTH    = 640,
   parameter int unsigned       IMG_HEIGHT   = 480,
   parameter int unsigned       DATA_W       = PIX_W,
   parameter logic [DATA_W-1:0] PAD_VALUE    = DATA_W'(8'hFF),
   parameter int unsigned       FLUSH_PIXELS = 2 * IMG_WIDTH + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [DATA_W-1:0] threshold,
   output logic              out_enable,
   output logic [DATA_W-1:0] out_data,
   output logic              frame_done,
   output logic              busy
`ifdef BINARIZE_STATS_EN
   ,
   output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] fg_count
`endif
);

   localparam int unsigned XW = cnt_w(IMG_WIDTH);
   localparam int unsigned YW = cnt_w(IMG_HEIGHT);
   localparam int unsigned FW = cnt_w(FLUSH_PIXELS + 1);

   localparam logic [XW-1:0]     XLast     = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0]     YLast     = YW'(IMG_HEIGHT - 1);
   localparam logic [FW-1:0]     FlushLast = FW'(FLUSH_PIXELS - 1);
   localparam logic [DATA_W-1:0] FgVal     = DATA_W'(PIX_FG);
   localparam logic [DATA_W-1:0] BgVal     = DATA_W'(PIX_BG);

   img_state_e        state_q, state_d;
   logic [FW-1:0]     flush_q, flush_d;
   logic [DATA_W-1:0] thr_q, thr_d;

   logic              out_en_q, out_en_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              accept;
   logic              pix_fg;
   logic              last_px;
   logic [DATA_W-1:0] thr_use;
   logic [XW-1:0]     pos_x;
   logic [YW-1:0]     pos_y;

   raster_counter #(
      .WIDTH  (IMG_WIDTH),
      .HEIGHT (IMG_HEIGHT)
   ) u_raster (
      .clk_i     (clk),
      .rst_i     (rst),
      .clear_i   (state_q == StDone),
      .advance_i (accept),
      .x_o       (pos_x),
      .y_o       (pos_y)
   );

   // In IDLE the position is always the origin, so this also covers 1x1 frames
   assign last_px = (pos_x == XLast) && (pos_y == YLast);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = last_px ? StFlush : StActive;
         end
         StActive: begin
            if (accept && last_px) state_d = StFlush;
         end
         StFlush: begin
            if (flush_q == FlushLast) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Handshake, classification and next values of the registered outputs
   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         StIdle:   in_ready = 1'b1;
         StActive: in_ready = 1'b1;
         StFlush:  in_ready = 1'b0;
         StDone:   in_ready = 1'b0;
         default:  in_ready = 1'b0;
      endcase

      accept = in_valid & in_ready;

      // The frame's first pixel uses the live threshold it is latched from
      thr_use = (state_q == StIdle) ? threshold : thr_q;
      pix_fg  = (in_data >= thr_use);

      thr_d = thr_q;
      if (accept && (state_q == StIdle)) thr_d = threshold;

      flush_d = (state_q == StFlush) ? flush_q + FW'(1) : '0;

      out_en_d   = accept | (state_q == StFlush);
      out_data_d = BgVal;
      if (accept) begin
         out_data_d = pix_fg ? FgVal : BgVal;
      end else if (state_q == StFlush) begin
         out_data_d = PAD_VALUE;
      end

      done_d = (state_q == StDone);
      busy_d = accept | (state_q != StIdle);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_q    <= '0;
         thr_q      <= '0;
         out_en_q   <= 1'b0;
         out_data_q <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         flush_q    <= flush_d;
         thr_q      <= thr_d;
         out_en_q   <= out_en_d;
         out_data_q <= out_data_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign out_enable = out_en_q;
   assign out_data   = out_data_q;
   assign frame_done = done_q;
   assign busy       = busy_q;

`ifdef BINARIZE_STATS_EN
   localparam int unsigned GW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

   logic [GW-1:0] fg_acc_q, fg_acc_d;
   logic [GW-1:0] fg_cnt_q, fg_cnt_d;

   // Foreground tally restarts with the frame's first pixel; published at DONE
   always_comb begin
      fg_acc_d = fg_acc_q;
      if (accept) begin
         fg_acc_d = ((state_q == StIdle) ? '0 : fg_acc_q) + GW'(pix_fg);
      end
      fg_cnt_d = (state_q == StDone) ? fg_acc_q : fg_cnt_q;
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fg_acc_q <= '0;
         fg_cnt_q <= '0;
      end else begin
         fg_acc_q <= fg_acc_d;
         fg_cnt_q <= fg_cnt_d;
      end
   end

   assign fg_count = fg_cnt_q;
`endif

endmodule

// File: tb/tb_binarize_stream.sv
// Self-checking bench for binarize_stream on a 4x3 frame with 10 pad pixels.
module tb_binarize_stream;

   localparam int unsigned W    = 4;
   localparam int unsigned H    = 3;
   localparam int unsigned FL   = 10;
   localparam int unsigned NPIX = W * H;
   localparam logic [7:0]  PAD  = 8'hFF;

   logic       clk, rst, in_valid, in_ready, out_enable, frame_done, busy;
   logic [7:0] in_data, threshold, out_data;
`ifdef BINARIZE_STATS_EN
   logic [$clog2(NPIX+1)-1:0] fg_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   binarize_stream #(
      .IMG_WIDTH    (W),
      .IMG_HEIGHT   (H),
      .DATA_W       (8),
      .PAD_VALUE    (PAD),
      .FLUSH_PIXELS (FL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .threshold  (threshold),
      .out_enable (out_enable),
      .out_data   (out_data),
      .frame_done (frame_done),
      .busy       (busy)
`ifdef BINARIZE_STATS_EN
      ,
      .fg_count   (fg_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame = NPIX accepted pixels, then FL pad cycles and one
   // done cycle with the input blocked. Evaluated at each falling edge for the
   // coming rising edge; expectations are compared one falling edge later.
   bit         mdl_ok = 0;
   int         pix_n, post, fg_acc;
   logic [7:0] thr_frame, thr_use;
   logic       rdy, acc, fg;
   logic       e_en, e_done, e_busy;
   logic [7:0] e_data;
   int         e_fgc;

   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("out_enable", out_enable, e_en);
         chk("out_data", out_data, e_data);
         chk("frame_done", frame_done, e_done);
         chk("busy", busy, e_busy);
`ifdef BINARIZE_STATS_EN
         chk("fg_count", fg_count, e_fgc);
`endif
      end
      if (rst) begin
         mdl_ok = 1;
         pix_n = 0; post = 0; fg_acc = 0; thr_frame = 0;
         e_en = 0; e_data = 0; e_done = 0; e_busy = 0; e_fgc = 0;
      end else if (mdl_ok) begin
         rdy = (post == 0);
         chk("in_ready", in_ready, rdy);
         acc     = in_valid && rdy;
         thr_use = (pix_n == 0) ? threshold : thr_frame;
         fg      = (in_data >= thr_use);
         e_en    = acc || (post >= 1 && post <= FL);
         e_data  = acc ? (fg ? 8'hFF : 8'h00) : ((post >= 1 && post <= FL) ? PAD : 8'h00);
         e_done  = (post == FL + 1);
         e_busy  = acc || (post > 0) || (pix_n > 0);
         if (post == FL + 1) e_fgc = fg_acc;
         if (acc) begin
            if (pix_n == 0) begin
               thr_frame = threshold;
               fg_acc = 0;
            end
            fg_acc += int'(fg);
            pix_n++;
            if (pix_n == NPIX) begin
               pix_n = 0;
               post = 1;
            end
         end else if (post > 0) begin
            post = (post == FL + 1) ? 0 : post + 1;
         end
      end
   end

   // Drives frames until `frames` frame_done pulses are seen.
   // mode 0: valid always high, 1: valid toggles, 2: random valid and threshold.
   task automatic run(input int mode, input int frames, input logic [7:0] thr0,
                      input logic [7:0] thr1, input int sw_after, output int stalls);
      int   acc_n = 0;
      int   done_n = 0;
      int   cyc = 0;
      logic tog = 1'b1;
      logic fire;
      stalls = 0;
      threshold = thr0;
      while (done_n < frames && cyc < 3000) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = tog;
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         tog = ~tog;
         in_data = 8'($urandom);
         if (mode == 2) threshold = 8'($urandom);
         else if (acc_n >= sw_after) threshold = thr1;
         fire = in_valid && in_ready;
         if (in_valid && !in_ready) stalls++;
         @(posedge clk); #1;
         if (fire) acc_n++;
         if (frame_done) done_n++;
         cyc++;
      end
      in_valid = 1'b0;
      chk("frame_done within budget", done_n, frames);
   endtask

   typedef struct {
      logic [7:0] pix;
      logic [7:0] exp;
   } vec_t;

   vec_t       tbl[NPIX];
   logic [7:0] pat[4];
   logic [7:0] bin[4];
   int         stalls;

   initial begin
      pat = '{8'h00, 8'h7F, 8'h80, 8'hFF};
      bin = '{8'h00, 8'h00, 8'hFF, 8'hFF};
      for (int i = 0; i < NPIX; i++) begin
         tbl[i].pix = pat[i % 4];
         tbl[i].exp = bin[i % 4];
      end

      rst = 1'b1; in_valid = 1'b0; in_data = '0; threshold = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_enable", out_enable, 0);
      chk("reset out_data", out_data, 0);
      chk("reset busy", busy, 0);
      chk("reset frame_done", frame_done, 0);

      // Table frame at threshold 0x80, continuous stream
      threshold = 8'h80;
      for (int i = 0; i < NPIX; i++) begin
         in_valid = 1'b1;
         in_data  = tbl[i].pix;
         @(posedge clk); #1;
         chk("table out_enable", out_enable, 1);
         chk("table out_data", out_data, tbl[i].exp);
      end
      in_valid = 1'b0;
      for (int k = 0; k < FL; k++) begin
         chk("flush in_ready", in_ready, 0);
         @(posedge clk); #1;
         chk("pad out_enable", out_enable, 1);
         chk("pad out_data", out_data, PAD);
         chk("pad frame_done", frame_done, 0);
      end
      chk("done in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("frame_done pulse", frame_done, 1);
      chk("busy with frame_done", busy, 1);
      chk("no enable after pad", out_enable, 0);
`ifdef BINARIZE_STATS_EN
      chk("table fg_count", fg_count, 6);
`endif
      @(posedge clk); #1;
      chk("frame_done one cycle", frame_done, 0);
      chk("busy falls", busy, 0);

      // Stalled frame; threshold moved to 0x10 after the third accept
      run(1, 1, 8'h80, 8'h10, 3, stalls);
      // Next frame picks up 0x10
      run(1, 1, 8'h10, 8'h10, 0, stalls);
`ifdef BINARIZE_STATS_EN
      chk("fg_count held into next frame", fg_count, e_fgc);
`endif

      // Valid held high across two frame boundaries
      run(0, 2, 8'h40, 8'h40, 0, stalls);
      chk("blocked cycles across boundaries", stalls, 2 * (FL + 1));

      // Reset in the fifth flush cycle
      threshold = 8'h80;
      for (int i = 0; i < NPIX; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort out_enable", out_enable, 0);
      chk("abort busy", busy, 0);
      chk("abort in_ready", in_ready, 1);
      chk("abort frame_done", frame_done, 0);
      repeat (FL) begin
         @(posedge clk); #1;
         chk("no frame_done after abort", frame_done, 0);
      end

      // Fresh and random frames
      run(2, 1, 8'h80, 8'h80, 0, stalls);
      run(2, 3, 8'h80, 8'h80, 0, stalls);
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/binarize_stream.md
Name: binarize_stream

Overview:
- Front-end stage that directly feeds the morphological filters (dilation/erosion).
- Thresholds a raster-order 8-bit grayscale stream into 0x00/0xFF binary pixels.
- Drives the filter's enable/data pair and tracks x/y position.
- After the last pixel of a frame, emits padding pixels so the filter's 3-line window flushes the final rows.

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
DATA_W, 8, pixel width
PAD_VALUE, 8'hFF, value emitted during flush (0xFF = neutral for the AND-window filter)
FLUSH_PIXELS, 2*IMG_WIDTH+2, number of padding pixels emitted after the last input pixel

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset; synchronous, active-high
in_valid  in  1  input pixel valid
in_data  in  DATA_W  grayscale pixel
in_ready  out  1  block can accept a pixel; combinational from state
threshold  in  DATA_W  binarization level, sampled at frame start
out_enable  out  1  pixel valid to the filter (its enable)
out_data  out  DATA_W  binary pixel 0x00/0xFF, or PAD_VALUE during flush
frame_done  out  1  one-cycle pulse after flush completes
busy  out  1  high from first accepted pixel until frame_done

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; x=0, y=0, flush_cnt=0; out_enable=0, out_data=0, frame_done=0, busy=0; latched threshold=0. in_ready=1 after reset. Reset mid-frame or mid-flush aborts immediately; no frame_done.
- Accept = in_valid & in_ready.
- Binarize: out_data = (in_data >= thr_latched) ? 8'hFF : 8'h00. Unsigned compare. Equality counts as foreground.
- Latency: 1 cycle, registered. Accept at cycle N gives out_enable=1 and out_data at cycle N+1.
- No accept in ACTIVE: out_enable=0, out_data=0. Position is held; stalls are allowed.
- States:
  - IDLE: in_ready=1, busy=0. On accept: threshold input latched and used for that same pixel; x=1 (or x=0,y=1 if IMG_WIDTH=1); -> ACTIVE.
  - ACTIVE: in_ready=1, busy=1. On accept, x increments. When x=IMG_WIDTH-1, x wraps to 0 and y increments. Accept at (IMG_WIDTH-1, IMG_HEIGHT-1) -> FLUSH, flush_cnt=0. Threshold input changes are ignored in this state.
  - FLUSH: in_ready=0; in_valid ignored; no data lost because the upstream holds. Each cycle: out_enable=1, out_data=PAD_VALUE, flush_cnt++. After FLUSH_PIXELS cycles -> DONE.
  - DONE: one cycle. frame_done=1; busy drops to 0 the next cycle; x=y=0; -> IDLE. in_ready=0 in DONE.
- Back-to-back frames: a pixel can be accepted in the cycle after DONE (IDLE); there is no dead cycle beyond FLUSH+DONE.
- Counter widths: $clog2 of IMG_WIDTH, IMG_HEIGHT, FLUSH_PIXELS+1 respectively. No overflow is possible by construction.

Optional Feature:
- Macro BINARIZE_STATS_EN.
- When defined, adds output fg_count [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0]:
  - counts accepted pixels classified 0xFF in the current frame;
  - internal accumulator cleared on the IDLE-state accept;
  - fg_count register updated with the final total in the DONE cycle, valid with frame_done and held until the next DONE;
  - reset value 0; padding pixels are never counted.
- When undefined, the port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package img_proc_pkg: pixel width constant PIX_W=8, PIX_FG=8'hFF, PIX_BG=8'h00, state enum typedef (IDLE, ACTIVE, FLUSH, DONE).
- One natural sub-module: raster_counter (x/y counter with wrap, last-pixel flag). It is reusable by the other img_proc stages.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, FLUSH_PIXELS=10):
- Reset then threshold=0x80, stream 12 pixels continuously, values 0x00,0x7F,0x80,0xFF repeated -> out_data 00,00,FF,FF repeated, one cycle after each accept; then 10 cycles of 0xFF padding with in_ready=0; frame_done pulse on the cycle after the last pad; busy falls the following cycle.
- Stall test: in_valid toggled 1/0 every cycle -> out_enable pattern mirrors accepts delayed 1; FLUSH entered only after the 12th accept.
- Change threshold from 0x80 to 0x10 after pixel 3 -> classification is unchanged for the rest of the frame; the next frame uses 0x10.
- Hold in_valid=1 across the frame boundary -> in_ready=0 for 11 cycles (FLUSH+DONE); the first pixel of frame 2 is accepted in IDLE with x/y restarting at 0.
- Assert rst during FLUSH cycle 5 -> next cycle: out_enable=0, busy=0, in_ready=1, no frame_done; a fresh frame then completes normally.
- With BINARIZE_STATS_EN, pattern 00,7F,80,FF at threshold 0x80 -> fg_count=6 at frame_done; remains 6 during the next frame until its DONE.
